field_offset_gen: RTL and testbench

- Upstream stage of the field-extraction lanes: turns one accepted header descriptor into per-lane extraction offsets.
- Each output offset carries a valid flag in its top bit, in the same format the extract lanes consume.
- Per header type, a programmable rule table gives up to FIELD_NUM relative field offsets.
- A small FSM issues them LANE_NUM at a time over one or more beats.

---
 rtl/field_offset_pkg.sv | 23 ++
 rtl/field_offset_lane.sv | 24 ++
 rtl/field_offset_gen.sv | 109 ++++++++++
 tb/tb_field_offset_gen.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/field_offset_pkg.sv
// Shared sizing defaults, lane offset format and FSM encoding for the field-offset generator.
// Each offset is a byte position in the candidate window, with a valid flag in the MSB.
package field_offset_pkg;

  localparam int LANE_NUM     = 8;
  localparam int FIELD_NUM    = 16;
  localparam int OFFSET_WIDTH = 7;
  localparam int TYPE_WIDTH   = 4;
  localparam int BEAT_NUM     = FIELD_NUM / LANE_NUM;

  typedef logic [OFFSET_WIDTH:0] offset_t;
  typedef offset_t [FIELD_NUM-1:0] rule_row_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  function automatic int beat_idx_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/field_offset_lane.sv
// One extract lane: header base plus relative field offset, with carry-out invalidating the lane.
// Purely combinational; the MSB of rule is the field enable and the MSB of offset is lane valid.
module field_offset_lane #(
  parameter int OFFSET_WIDTH = field_offset_pkg::OFFSET_WIDTH
) (
  input  logic [OFFSET_WIDTH-1:0] base,
  input  logic [OFFSET_WIDTH:0]   rule,
  output logic [OFFSET_WIDTH:0]   offset,
  output logic                    ovf
);
  import field_offset_pkg::*;

  logic [OFFSET_WIDTH:0] sum;
  logic                  en;
  logic                  lane_vld;

  assign en       = rule[OFFSET_WIDTH];
  assign sum      = {1'b0, base} + {1'b0, rule[OFFSET_WIDTH-1:0]};
  assign lane_vld = en & ~sum[OFFSET_WIDTH];
  assign offset   = lane_vld ? {1'b1, sum[OFFSET_WIDTH-1:0]} : '0;
  // Disabled fields never flag an overflow, whatever their stored offset.
  assign ovf      = en & sum[OFFSET_WIDTH];

endmodule

// File: rtl/field_offset_gen.sv
// Turns an accepted header descriptor into LANE_NUM offsets per beat, first beat registered one cycle after accept.
// No output backpressure; optional FIELD_OFFSET_GEN_B2B_EN also accepts on the last beat for bubble-free headers.
module field_offset_gen #(
  parameter int LANE_NUM     = field_offset_pkg::LANE_NUM,
  parameter int FIELD_NUM    = field_offset_pkg::FIELD_NUM,
  parameter int OFFSET_WIDTH = field_offset_pkg::OFFSET_WIDTH,
  parameter int TYPE_WIDTH   = field_offset_pkg::TYPE_WIDTH
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_cfg_wren,
  input  logic [TYPE_WIDTH-1:0]                 i_cfg_type,
  input  logic [$clog2(FIELD_NUM)-1:0]          i_cfg_field,
  input  logic [OFFSET_WIDTH:0]                 i_cfg_wdata,
  input  logic                                  i_hdr_valid,
  output logic                                  o_hdr_ready,
  input  logic [TYPE_WIDTH-1:0]                 i_hdr_type,
  input  logic [OFFSET_WIDTH-1:0]               i_hdr_base,
  output logic [LANE_NUM*(OFFSET_WIDTH+1)-1:0]  o_offset,
  output logic                                  o_offset_valid,
  output logic [((FIELD_NUM/LANE_NUM) > 1 ? $clog2(FIELD_NUM/LANE_NUM) : 1)-1:0] o_beat_idx,
  output logic                                  o_beat_last,
  output logic                                  o_err_ovf
);
  import field_offset_pkg::*;

  localparam int W     = OFFSET_WIDTH + 1;
  localparam int BEATS = FIELD_NUM / LANE_NUM;
  localparam int BW    = beat_idx_width(BEATS);
`ifdef FIELD_OFFSET_GEN_B2B_EN
  localparam bit B2B_EN = 1'b1;
`else
  localparam bit B2B_EN = 1'b0;
`endif

  logic [FIELD_NUM*W-1:0]    rule_tbl [2**TYPE_WIDTH];
  logic [FIELD_NUM*W-1:0]    row_q;
  logic [FIELD_NUM*W-1:0]    load_row;
  logic [OFFSET_WIDTH-1:0]   base_q;
  logic [OFFSET_WIDTH-1:0]   load_base;
  logic [LANE_NUM*W-1:0]     beat_rules;
  logic [LANE_NUM*W-1:0]     lane_off;
  logic [LANE_NUM-1:0]       lane_ovf;
  logic [BW-1:0]             load_idx;
  logic                      accept;
  logic                      load_vld;
  logic                      load_last;
  state_t                    state;

  // The beat being loaded into the output registers: beat 0 of a new header
  // straight from the table, or the next beat of the in-flight snapshot.
  assign accept     = i_hdr_valid & o_hdr_ready;
  assign load_vld   = accept | (state == ISSUE && !o_beat_last);
  assign load_idx   = accept ? '0 : o_beat_idx + 1'b1;
  assign load_last  = (load_idx == BW'(BEATS - 1));
  assign load_row   = accept ? rule_tbl[i_hdr_type] : row_q;
  assign load_base  = accept ? i_hdr_base : base_q;
  assign beat_rules = load_row[load_idx*LANE_NUM*W +: LANE_NUM*W];

  for (genvar j = 0; j < LANE_NUM; j++) begin : g_lane
    field_offset_lane #(
      .OFFSET_WIDTH(OFFSET_WIDTH)
    ) u_lane (
      .base  (load_base),
      .rule  (beat_rules[j*W +: W]),
      .offset(lane_off[j*W +: W]),
      .ovf   (lane_ovf[j])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int t = 0; t < 2**TYPE_WIDTH; t++) begin
        rule_tbl[t] <= '0;
      end
    end else if (i_cfg_wren) begin
      rule_tbl[i_cfg_type][i_cfg_field*W +: W] <= i_cfg_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      row_q          <= '0;
      base_q         <= '0;
      o_hdr_ready    <= 1'b1;
      o_offset       <= '0;
      o_offset_valid <= 1'b0;
      o_beat_idx     <= '0;
      o_beat_last    <= 1'b0;
      o_err_ovf      <= 1'b0;
    end else begin
      if (accept) begin
        row_q  <= rule_tbl[i_hdr_type];
        base_q <= i_hdr_base;
      end
      state          <= load_vld ? ISSUE : IDLE;
      o_hdr_ready    <= !load_vld || (B2B_EN && load_last);
      o_offset       <= load_vld ? lane_off : '0;
      o_offset_valid <= load_vld;
      o_beat_idx     <= load_vld ? load_idx : '0;
      o_beat_last    <= load_vld && load_last;
      if (load_vld && |lane_ovf) begin
        o_err_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_field_offset_gen.sv
// Directed bench for field_offset_gen with a beat scoreboard filled at accept time.
// Honours FIELD_OFFSET_GEN_B2B_EN for the ready timing and back-to-back gap expectations.
module tb_field_offset_gen;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_cfg_wren = 1'b0;
  logic [3:0]  i_cfg_type = '0;
  logic [3:0]  i_cfg_field = '0;
  logic [7:0]  i_cfg_wdata = '0;
  logic        i_hdr_valid = 1'b0;
  logic        o_hdr_ready;
  logic [3:0]  i_hdr_type = '0;
  logic [6:0]  i_hdr_base = '0;
  logic [63:0] o_offset;
  logic        o_offset_valid;
  logic [0:0]  o_beat_idx;
  logic        o_beat_last;
  logic        o_err_ovf;

`ifdef FIELD_OFFSET_GEN_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  field_offset_gen dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_cfg_wren    (i_cfg_wren),
    .i_cfg_type    (i_cfg_type),
    .i_cfg_field   (i_cfg_field),
    .i_cfg_wdata   (i_cfg_wdata),
    .i_hdr_valid   (i_hdr_valid),
    .o_hdr_ready   (o_hdr_ready),
    .i_hdr_type    (i_hdr_type),
    .i_hdr_base    (i_hdr_base),
    .o_offset      (o_offset),
    .o_offset_valid(o_offset_valid),
    .o_beat_idx    (o_beat_idx),
    .o_beat_last   (o_beat_last),
    .o_err_ovf     (o_err_ovf)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] off;
    logic        idx;
    logic        last;
    logic        ovf;
  } beat_t;

  beat_t      sb[$];
  int         vcyc[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic       ovf_acc = 1'b0;
  logic [7:0] mtbl [16][16];

  always @(posedge i_clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beats of one header from the bench's copy of the rule table.
  task automatic push_hdr(input int t, input logic [6:0] base);
    for (int k = 0; k < 2; k++) begin
      beat_t e;
      e.off = '0;
      for (int j = 0; j < 8; j++) begin
        logic [7:0] r;
        logic [7:0] s;
        r = mtbl[t][k*8+j];
        s = {1'b0, base} + {1'b0, r[6:0]};
        if (r[7] && s[7]) ovf_acc = 1'b1;
        e.off[j*8 +: 8] = (r[7] && !s[7]) ? {1'b1, s[6:0]} : 8'h00;
      end
      e.idx  = (k == 1);
      e.last = (k == 1);
      e.ovf  = ovf_acc;
      sb.push_back(e);
    end
  endtask

  always @(negedge i_clk) begin
    beat_t e;
    if (i_rst_n && o_offset_valid) begin
      vcyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_beat", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("beat_off", o_offset, e.off);
        chk("beat_idx", o_beat_idx, e.idx);
        chk("beat_last", o_beat_last, e.last);
        chk("err_ovf", o_err_ovf, e.ovf);
      end
    end else if (i_rst_n) begin
      chk("idle_off", o_offset, 0);
      chk("idle_last", o_beat_last, 0);
    end
  end

  task automatic cfg_write(input int t, input int f, input int rel, input bit en);
    i_cfg_wren  = 1'b1;
    i_cfg_type  = t[3:0];
    i_cfg_field = f[3:0];
    i_cfg_wdata = {en, rel[6:0]};
    @(posedge i_clk);
    @(negedge i_clk);
    i_cfg_wren  = 1'b0;
    mtbl[t][f]  = {en, rel[6:0]};
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (o_hdr_ready) break;
      @(negedge i_clk);
    end
    chk("ready_wait", o_hdr_ready, 1);
  endtask

  task automatic send_hdr(input int t, input logic [6:0] base);
    i_hdr_valid = 1'b1;
    i_hdr_type  = t[3:0];
    i_hdr_base  = base;
    wait_ready();
    push_hdr(t, base);
    @(posedge i_clk);
    @(negedge i_clk);
    i_hdr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && !o_offset_valid && o_hdr_ready) break;
      @(negedge i_clk);
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int t = 0; t < 16; t++)
      for (int f = 0; f < 16; f++)
        mtbl[t][f] = 8'h00;

    repeat (2) @(negedge i_clk);
    chk("rst_valid", o_offset_valid, 0);
    chk("rst_off", o_offset, 0);
    chk("rst_ovf", o_err_ovf, 0);
    chk("rst_last", o_beat_last, 0);
    chk("rst_idx", o_beat_idx, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_ready", o_hdr_ready, 1);

    // Type 3: every field enabled with rel = f.
    for (int f = 0; f < 16; f++) cfg_write(3, f, f, 1'b1);
    send_hdr(3, 7'd10);
    chk("t1_beat0", o_offset, 64'h9190_8f8e_8d8c_8b8a);
    chk("t1_ready_b0", o_hdr_ready, 0);
    @(negedge i_clk);
    chk("t1_beat1", o_offset, 64'h9998_9796_9594_9392);
    chk("t1_last", o_beat_last, 1);
    chk("t1_ready_b1", o_hdr_ready, B2B);
    @(negedge i_clk);
    chk("t1_ready_back", o_hdr_ready, 1);
    chk("t1_valid_off", o_offset_valid, 0);
    drain();

    // Type 5: only field 2 enabled.
    cfg_write(5, 2, 4, 1'b1);
    send_hdr(5, 7'd0);
    chk("t2_beat0", o_offset, 64'h0000_0000_0084_0000);
    drain();

    // Type 1: 120 + 10 carries out of the window.
    cfg_write(1, 0, 10, 1'b1);
    send_hdr(1, 7'd120);
    chk("t3_lane0", o_offset[7:0], 8'h00);
    chk("t3_ovf", o_err_ovf, 1);
    drain();

    // Write during beat 0 of a type-3 header only affects later headers.
    send_hdr(3, 7'd10);
    chk("t4_old", o_offset[7:0], 8'h8a);
    cfg_write(3, 0, 50, 1'b1);
    drain();
    send_hdr(3, 7'd10);
    chk("t4_new", o_offset[7:0], 8'hbc);
    chk("t4_ovf_sticky", o_err_ovf, 1);
    drain();

    // Write to the same type in the accept cycle is not seen by that header.
    i_cfg_wren  = 1'b1;
    i_cfg_type  = 4'd3;
    i_cfg_field = 4'd1;
    i_cfg_wdata = 8'h00;
    i_hdr_valid = 1'b1;
    i_hdr_type  = 4'd3;
    i_hdr_base  = 7'd10;
    wait_ready();
    push_hdr(3, 7'd10);
    mtbl[3][1] = 8'h00;
    @(posedge i_clk);
    @(negedge i_clk);
    i_cfg_wren  = 1'b0;
    i_hdr_valid = 1'b0;
    chk("t4b_same_cycle", o_offset[15:8], 8'h8b);
    drain();
    send_hdr(3, 7'd10);
    chk("t4b_next", o_offset[15:8], 8'h00);
    drain();

    // Reset during beat 0.
    send_hdr(3, 7'd10);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("t5_valid_drop", o_offset_valid, 0);
    chk("t5_ovf_clear", o_err_ovf, 0);
    sb.delete();
    ovf_acc = 1'b0;
    for (int t = 0; t < 16; t++)
      for (int f = 0; f < 16; f++)
        mtbl[t][f] = 8'h00;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("t5_ready", o_hdr_ready, 1);
    send_hdr(3, 7'd10);
    chk("t5_cleared", o_offset, 0);
    drain();

    // Two headers offered continuously.
    for (int f = 0; f < 16; f++) cfg_write(3, f, f, 1'b1);
    vcyc.delete();
    i_hdr_valid = 1'b1;
    i_hdr_type  = 4'd3;
    i_hdr_base  = 7'd10;
    wait_ready();
    push_hdr(3, 7'd10);
    @(posedge i_clk);
    @(negedge i_clk);
    i_hdr_base = 7'd20;
    wait_ready();
    push_hdr(3, 7'd20);
    @(posedge i_clk);
    @(negedge i_clk);
    i_hdr_valid = 1'b0;
    drain();
    chk("b2b_count", vcyc.size(), 4);
    if (vcyc.size() >= 4) begin
      chk("b2b_gap01", vcyc[1] - vcyc[0], 1);
      chk("b2b_gap12", vcyc[2] - vcyc[1], B2B ? 1 : 2);
      chk("b2b_gap23", vcyc[3] - vcyc[2], 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
